// File: rtl/count_seq_monitor.sv
// Run-time checker for a free-running up-counter: verifies the 1,2 restart after the
// observed reset, then every increment; reports via pulse, sticky and saturating count.
module count_seq_monitor #(
  parameter int WIDTH      = 4,
  parameter int ERR_CNT_W  = 8,
  parameter bit ALLOW_WRAP = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 obs_reset_n,
  input  logic [WIDTH-1:0]     count,
  output logic                 seq_ok,
  output logic                 err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [WIDTH-1:0]     expected,
  output logic                 tracking
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IN_RST = 3'd1,
    EXP1   = 3'd2,
    EXP2   = 3'd3,
    TRACK  = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0]     ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0]     TWO      = WIDTH'(2);
  localparam logic [WIDTH-1:0]     ALL_ONES = '1;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] prev_inc;
  logic             wrap_bad;
  logic             chk_fail;
  logic [WIDTH-1:0] chk_exp;

  assign prev_inc = prev + ONE;
  // With wrap disallowed, all-ones -> 0 is flagged even though it equals prev+1 mod 2^WIDTH.
  assign wrap_bad = !ALLOW_WRAP && (prev == ALL_ONES) && (count == '0);

  always_comb begin
    chk_fail = 1'b0;
    chk_exp  = prev_inc;
    case (state)
      EXP1: begin
        chk_fail = (count != ONE);
        chk_exp  = ONE;
      end
      EXP2: begin
        chk_fail = (count != TWO);
        chk_exp  = TWO;
      end
      TRACK: begin
        chk_fail = (count != prev_inc) || wrap_bad;
        chk_exp  = prev_inc;
      end
      default: begin
        chk_fail = 1'b0;
        chk_exp  = prev_inc;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      prev       <= '0;
      seq_ok     <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      err_count  <= '0;
      expected   <= '0;
      tracking   <= 1'b0;
    end else begin
      seq_ok   <= 1'b0;
      err      <= 1'b0;
      tracking <= (state == TRACK);
      // Observed reset masks every compare in the same cycle.
      if (!obs_reset_n) begin
        state <= IN_RST;
      end else begin
        case (state)
          IDLE:   state <= IDLE;
          IN_RST: state <= EXP1;
          EXP1:   state <= chk_fail ? IDLE : EXP2;
          EXP2: begin
            if (chk_fail) begin
              state <= IDLE;
            end else begin
              state  <= TRACK;
              seq_ok <= 1'b1;
              prev   <= count;
            end
          end
          TRACK:  prev <= count;
          default: state <= IDLE;
        endcase
        if (chk_fail) begin
          err        <= 1'b1;
          err_sticky <= 1'b1;
          expected   <= chk_exp;
          if (err_count != ERR_MAX) err_count <= err_count + ERR_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed-vector bench: two monitors (wrap allowed / disallowed) share one stimulus stream.
module tb_count_seq_monitor;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       obs_reset_n = 1'b1;
  logic [3:0] count = '0;

  logic       w_seq_ok, w_err, w_sticky, w_trk;
  logic [7:0] w_cnt;
  logic [3:0] w_exp;
  logic       n_seq_ok, n_err, n_sticky, n_trk;
  logic [7:0] n_cnt;
  logic [3:0] n_exp;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  count_seq_monitor #(.WIDTH(4), .ERR_CNT_W(8), .ALLOW_WRAP(1'b1)) dut_w (
    .clk(clk), .reset_n(reset_n), .obs_reset_n(obs_reset_n), .count(count),
    .seq_ok(w_seq_ok), .err(w_err), .err_sticky(w_sticky), .err_count(w_cnt),
    .expected(w_exp), .tracking(w_trk)
  );

  count_seq_monitor #(.WIDTH(4), .ERR_CNT_W(8), .ALLOW_WRAP(1'b0)) dut_nw (
    .clk(clk), .reset_n(reset_n), .obs_reset_n(obs_reset_n), .count(count),
    .seq_ok(n_seq_ok), .err(n_err), .err_sticky(n_sticky), .err_count(n_cnt),
    .expected(n_exp), .tracking(n_trk)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // Drive one vector at negedge; return just after the posedge that samples it.
  task automatic step(input logic orn, input logic [3:0] c);
    @(negedge clk);
    obs_reset_n = orn;
    count       = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".seq_ok"},   32'(w_seq_ok), 0);
    chk({tag, ".err"},      32'(w_err),    0);
    chk({tag, ".sticky"},   32'(w_sticky), 0);
    chk({tag, ".err_cnt"},  32'(w_cnt),    0);
    chk({tag, ".expected"}, 32'(w_exp),    0);
    chk({tag, ".tracking"}, 32'(w_trk),    0);
    chk({tag, ".nw_cnt"},   32'(n_cnt),    0);
    chk({tag, ".nw_stk"},   32'(n_sticky), 0);
  endtask

  initial begin
    // Reset state
    reset_n = 1'b0;
    step(1'b1, 4'd0);
    step(1'b1, 4'd0);
    chk_all_zero("reset");
    reset_n = 1'b1;

    // 1) Clean startup and a full lap with wrap
    step(1'b0, 4'd0);
    step(1'b0, 4'd0);
    step(1'b1, 4'd0);
    step(1'b1, 4'd1);
    chk("t1.no_seq_early", 32'(w_seq_ok), 0);
    step(1'b1, 4'd2);
    chk("t1.seq_ok",  32'(w_seq_ok), 1);
    chk("t1.trk_lag", 32'(w_trk),    0);
    step(1'b1, 4'd3);
    chk("t1.seq_once", 32'(w_seq_ok), 0);
    chk("t1.tracking", 32'(w_trk),    1);
    for (int v = 4; v <= 15; v++) begin
      step(1'b1, 4'(v));
      chk("t1.lap_err", 32'(w_err),    0);
      chk("t1.lap_seq", 32'(w_seq_ok), 0);
    end

    // 4) Wrap 15 -> 0: legal for one instance, flagged by the other
    step(1'b1, 4'd0);
    chk("t4.w_err",  32'(w_err), 0);
    chk("t4.nw_err", 32'(n_err), 1);
    chk("t4.nw_exp", 32'(n_exp), 0);
    step(1'b1, 4'd1);
    chk("t4.nw_err_clr", 32'(n_err),    0);
    chk("t4.nw_cnt",     32'(n_cnt),    1);
    chk("t4.w_sticky",   32'(w_sticky), 0);
    chk("t4.w_cnt",      32'(w_cnt),    0);

    // 3) Skip in TRACK, then resync
    for (int v = 2; v <= 6; v++) step(1'b1, 4'(v));
    chk("t3.pre_err", 32'(w_err), 0);
    step(1'b1, 4'd9);
    chk("t3.err",      32'(w_err),    1);
    chk("t3.expected", 32'(w_exp),    7);
    chk("t3.sticky",   32'(w_sticky), 1);
    step(1'b1, 4'd10);
    chk("t3.resync",   32'(w_err), 0);
    chk("t3.exp_hold", 32'(w_exp), 7);
    step(1'b1, 4'd11);
    chk("t3.no_err", 32'(w_err), 0);
    chk("t3.cnt",    32'(w_cnt), 1);
    chk("t3.nw_cnt", 32'(n_cnt), 2);

    // 5) Observed reset masks a bad count while tracking
    step(1'b0, 4'd7);
    chk("t5.masked", 32'(w_err), 0);
    step(1'b1, 4'd0);
    chk("t5.trk_drop", 32'(w_trk), 0);
    step(1'b1, 4'd1);
    step(1'b1, 4'd2);
    chk("t5.seq_ok", 32'(w_seq_ok), 1);
    chk("t5.cnt",    32'(w_cnt),    1);

    // Glitch 0 -> 1 -> 0 on the observed reset
    step(1'b0, 4'd0);
    step(1'b1, 4'd0);
    step(1'b0, 4'd5);
    chk("gl.no_err", 32'(w_err), 0);
    step(1'b1, 4'd0);
    step(1'b1, 4'd1);
    chk("gl.no_err2", 32'(w_err), 0);
    step(1'b1, 4'd2);
    chk("gl.seq_ok", 32'(w_seq_ok), 1);

    // 2) Bad first value after release
    step(1'b0, 4'd0);
    step(1'b1, 4'd0);
    step(1'b1, 4'd3);
    chk("t2.err",      32'(w_err),    1);
    chk("t2.expected", 32'(w_exp),    1);
    chk("t2.sticky",   32'(w_sticky), 1);
    chk("t2.cnt",      32'(w_cnt),    2);
    step(1'b1, 4'd4);
    chk("t2.err_clr", 32'(w_err), 0);
    step(1'b1, 4'd9);
    chk("t2.idle_no_err", 32'(w_err), 0);
    chk("t2.idle_trk",    32'(w_trk), 0);
    chk("t2.cnt_hold",    32'(w_cnt), 2);

    // 6) 300 mismatches saturate the error count
    step(1'b0, 4'd0);
    step(1'b1, 4'd0);
    step(1'b1, 4'd1);
    step(1'b1, 4'd2);
    step(1'b1, 4'd3);
    for (int i = 0; i < 300; i++) step(1'b1, 4'd3);
    chk("t6.err",    32'(w_err), 1);
    chk("t6.exp",    32'(w_exp), 4);
    chk("t6.sat",    32'(w_cnt), 255);
    chk("t6.nw_sat", 32'(n_cnt), 255);

    // reset_n mid-sequence clears everything; monitor needs re-arming
    step(1'b0, 4'd0);
    step(1'b1, 4'd0);
    step(1'b1, 4'd1);
    reset_n = 1'b0;
    step(1'b1, 4'd2);
    chk_all_zero("midrst");
    reset_n = 1'b1;
    step(1'b1, 4'd2);
    chk("midrst.no_seq", 32'(w_seq_ok), 0);
    chk("midrst.no_err", 32'(w_err),    0);
    step(1'b1, 4'd7);
    chk("midrst.idle", 32'(w_err), 0);
    chk("midrst.trk",  32'(w_trk), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
